// File: rtl/param_sync_fifo_pkg.sv
// Shared definitions for param_sync_fifo: pointer/level width helpers,
// default almost-full/almost-empty thresholds and the output-mode selector.
// Mode is chosen at compile time by PARAM_SYNC_FIFO_FWFT_EN.
package param_sync_fifo_pkg;

    localparam bit STD  = 1'b0;
    localparam bit FWFT = 1'b1;

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    localparam bit MODE = FWFT;
`else
    localparam bit MODE = STD;
`endif

    // aempty threshold and distance of the afull threshold below DEPTH
    localparam int AE_DEFAULT = 6;
    localparam int AF_MARGIN  = 6;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // one extra bit so the level can represent DEPTH itself
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_sdp_ram.sv
// Simple dual-port storage for param_sync_fifo: one write port and one
// registered read port. The array itself has no reset so it maps onto
// block RAM; only the read register is reset.
module fifo_sdp_ram
    import param_sync_fifo_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ptr_w(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]           wr_data,
    input  logic                    rd_en,
    input  logic [ptr_w(DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]           rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // registered read port; holds its value between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with fill level, almost-full/empty flags,
// sticky overflow/underflow and synchronous flush (clr).
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through output;
// otherwise reads have one cycle of latency.
// The read-data port is named dout because "do" is a reserved word.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 1024,
    parameter int AF_LEVEL = DEPTH - AF_MARGIN,
    parameter int AE_LEVEL = AE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   we,
    input  logic [DW-1:0]          di,
    input  logic                   re,
    output logic [DW-1:0]          dout,
    output logic                   empty_flag,
    output logic                   full_flag,
    output logic                   afull_flag,
    output logic                   aempty_flag,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW      = ptr_w(DEPTH);
    localparam int LW      = lvl_w(DEPTH);
    localparam bit IS_FWFT = (MODE == FWFT);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [LW-1:0] level_nxt;
    logic          wr_ok;
    logic          rd_ok;
    logic          ram_we;
    logic          ram_re;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] out_q;
    logic          empty_nxt;

    // rejection is decided purely by the registered flags
    assign wr_ok  = we & ~full_flag;
    assign rd_ok  = re & ~empty_flag;
    assign ram_we = wr_ok & ~clr;

    // next fill level; a simultaneous accepted write and read cancel
    always_comb begin
        level_nxt = level;
        if (wr_ok && !rd_ok) begin
            level_nxt = level + LW'(1);
        end else if (!wr_ok && rd_ok) begin
            level_nxt = level - LW'(1);
        end
    end

    fifo_sdp_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we),
        .wr_addr (wptr),
        .wr_data (di),
        .rd_en   (ram_re),
        .rd_addr (rptr),
        .rd_data (ram_q)
    );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Prefetch pipeline: RAM read register (pend) feeds the output stage.
    // level counts words in RAM, in the read register and in the output
    // stage, so the words still in RAM are what is left over.
    logic          pend;
    logic          load_out;
    logic [LW-1:0] ram_cnt;

    assign ram_cnt   = level - LW'(pend) - LW'(~empty_flag);
    assign load_out  = pend & (empty_flag | re);
    assign ram_re    = ~clr & (ram_cnt != '0) & (~pend | load_out);
    assign empty_nxt = ~(load_out | (~empty_flag & ~re));

    // output stage and read-register occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            out_q <= '0;
        end else if (clr) begin
            pend  <= 1'b0;
            out_q <= '0;
        end else begin
            pend <= ram_re | (pend & ~load_out);
            if (load_out) begin
                out_q <= ram_q;
            end
        end
    end
`else
    assign ram_re    = rd_ok & ~clr;
    assign empty_nxt = (level_nxt == '0);
    assign out_q     = '0;
`endif

    assign dout = IS_FWFT ? out_q : ram_q;

    // pointers, level, registered flags and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            empty_flag  <= 1'b1;
            full_flag   <= 1'b0;
            afull_flag  <= 1'b0;
            aempty_flag <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (clr) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            empty_flag  <= 1'b1;
            full_flag   <= 1'b0;
            afull_flag  <= 1'b0;
            aempty_flag <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (ram_we) begin
                wptr <= wptr + PW'(1);
            end
            if (ram_re) begin
                rptr <= rptr + PW'(1);
            end
            level       <= level_nxt;
            empty_flag  <= empty_nxt;
            full_flag   <= (level_nxt == LW'(DEPTH));
            afull_flag  <= (level_nxt >= LW'(AF_LEVEL));
            aempty_flag <= (level_nxt <= LW'(AE_LEVEL));
            if (we && full_flag) begin
                overflow <= 1'b1;
            end
            if (re && empty_flag) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
